logo_motion_ctrl: RTL

Per-frame motion controller for the VGA text-overlay renderer. It owns the 32-bit `center` word (`y` in bits [31:16], `x` in bits [15:0]) that places the overlay, and moves it once per frame with edge bounce. It updates only at the start of vertical sync, so the active area never tears. A host-side command port starts and stops motion and loads position and velocity.

---
 rtl/logo_motion_ctrl.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/logo_motion_ctrl.sv
// logo_motion_ctrl
// Moves the text-overlay anchor ("center" = {y, x}) once per frame, bouncing
// off the visible-area edges. Position only changes right after the falling
// edge of vsync, so the renderer never sees a mid-frame jump. A small command
// port lets the host start/stop motion and load a new position or velocity.
module logo_motion_ctrl #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int OBJ_W     = 141,
    parameter int OBJ_H     = 40,
    parameter int FRAME_DIV = 1,
    parameter int X0        = 0,
    parameter int Y0        = 0
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        vga_vs,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_data,
    output logic [31:0] center,
    output logic        frame_tick,
    output logic        running
);

    // Largest legal top-left coordinate that keeps the overlay fully visible.
    localparam logic [15:0]        XMAX   = 16'(H_ACTIVE - OBJ_W);
    localparam logic [15:0]        YMAX   = 16'(V_ACTIVE - OBJ_H);
    localparam logic signed [16:0] XMAX_S = 17'(H_ACTIVE - OBJ_W);
    localparam logic signed [16:0] YMAX_S = 17'(V_ACTIVE - OBJ_H);

    localparam int               DIV_W    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

    localparam logic [1:0] OP_STOP    = 2'd0;
    localparam logic [1:0] OP_START   = 2'd1;
    localparam logic [1:0] OP_SET_POS = 2'd2;
    localparam logic [1:0] OP_SET_VEL = 2'd3;

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              vsPrev_q;
    logic              frameTick_q;
    logic [15:0]       posX_q, posX_d;
    logic [15:0]       posY_q, posY_d;
    logic signed [7:0] velX_q, velX_d;
    logic signed [7:0] velY_q, velY_d;
    logic [DIV_W-1:0]  divCnt_q, divCnt_d;
    logic              pend_q, pend_d;
    logic [15:0]       shadowX_q, shadowX_d;
    logic [15:0]       shadowY_q, shadowY_d;

    logic              frameEdge;
    logic              cmdAccept;
    logic              stopCmd, startCmd, setPosCmd, setVelCmd;
    logic              divHit;
    logic signed [16:0] sumX, sumY;
    logic [15:0]       stepX, stepY;
    logic signed [7:0] stepVelX, stepVelY;

    // -128 has no positive twin in 8 bits, so it is pulled in to -127 on load.
    function automatic logic signed [7:0] satVel(input logic [7:0] v);
        return (v == 8'h80) ? 8'sh81 : $signed(v);
    endfunction

    function automatic logic [15:0] clampPos(input logic [15:0] v, input logic [15:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    assign frameEdge = vsPrev_q & ~vga_vs;
    assign cmd_ready = (state_q != ST_STEP);
    assign cmdAccept = cmd_valid & cmd_ready;
    assign stopCmd   = cmdAccept & (cmd_op == OP_STOP);
    assign startCmd  = cmdAccept & (cmd_op == OP_START);
    assign setPosCmd = cmdAccept & (cmd_op == OP_SET_POS);
    assign setVelCmd = cmdAccept & (cmd_op == OP_SET_VEL);
    assign divHit    = (divCnt_q == DIV_LAST);

    assign center     = {posY_q, posX_q};
    assign frame_tick = frameTick_q;
    assign running    = (state_q == ST_RUN) || (state_q == ST_STEP);

    // Bounce arithmetic: one signed add per axis, reflect velocity at either wall.
    always_comb begin
        sumX     = $signed({1'b0, posX_q}) + $signed({{9{velX_q[7]}}, velX_q});
        sumY     = $signed({1'b0, posY_q}) + $signed({{9{velY_q[7]}}, velY_q});
        stepX    = sumX[15:0];
        stepY    = sumY[15:0];
        stepVelX = velX_q;
        stepVelY = velY_q;
        if (sumX[16]) begin
            stepX    = '0;
            stepVelX = -velX_q;
        end else if (sumX > XMAX_S) begin
            stepX    = XMAX;
            stepVelX = -velX_q;
        end
        if (sumY[16]) begin
            stepY    = '0;
            stepVelY = -velY_q;
        end else if (sumY > YMAX_S) begin
            stepY    = YMAX;
            stepVelY = -velY_q;
        end
    end

    // Control FSM: a step is taken only on a divided frame edge with no commit pending,
    // and a STOP arriving on that same edge cancels it.
    always_comb begin
        state_d  = state_q;
        divCnt_d = divCnt_q;
        unique case (state_q)
            ST_STOP: begin
                if (startCmd) begin
                    state_d  = ST_RUN;
                    divCnt_d = '0;
                end
            end
            ST_RUN: begin
                if (frameEdge) begin
                    divCnt_d = divHit ? '0 : divCnt_q + DIV_W'(1);
                end
                if (stopCmd) begin
                    state_d = ST_STOP;
                end else if (frameEdge && divHit && !pend_q) begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_STOP;
            end
        endcase
    end

    // Position/velocity datapath: step result, shadow commit on vsync, command loads.
    always_comb begin
        posX_d    = posX_q;
        posY_d    = posY_q;
        velX_d    = velX_q;
        velY_d    = velY_q;
        pend_d    = pend_q;
        shadowX_d = shadowX_q;
        shadowY_d = shadowY_q;

        if (state_q == ST_STEP) begin
            posX_d = stepX;
            posY_d = stepY;
            velX_d = stepVelX;
            velY_d = stepVelY;
        end

        if (setPosCmd) begin
            shadowX_d = clampPos(cmd_data[15:0], XMAX);
            shadowY_d = clampPos(cmd_data[31:16], YMAX);
            pend_d    = 1'b1;
        end else if (frameEdge && pend_q) begin
            posX_d = shadowX_q;
            posY_d = shadowY_q;
            pend_d = 1'b0;
        end

        if (setVelCmd) begin
            velX_d = satVel(cmd_data[7:0]);
            velY_d = satVel(cmd_data[15:8]);
        end
    end

    // State and datapath registers; reset drops any pending position load.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_STOP;
            vsPrev_q    <= 1'b1;
            frameTick_q <= 1'b0;
            posX_q      <= 16'(X0);
            posY_q      <= 16'(Y0);
            velX_q      <= 8'sd1;
            velY_q      <= 8'sd1;
            divCnt_q    <= '0;
            pend_q      <= 1'b0;
            shadowX_q   <= '0;
            shadowY_q   <= '0;
        end else begin
            state_q     <= state_d;
            vsPrev_q    <= vga_vs;
            frameTick_q <= frameEdge;
            posX_q      <= posX_d;
            posY_q      <= posY_d;
            velX_q      <= velX_d;
            velY_q      <= velY_d;
            divCnt_q    <= divCnt_d;
            pend_q      <= pend_d;
            shadowX_q   <= shadowX_d;
            shadowY_q   <= shadowY_d;
        end
    end

endmodule
